// File: rtl/lii_stream_adapter_if.sv
// Handshake bundle between an LII phy channel pair and an HLS kernel AXI-Stream pair.
// The slave modport is the adapter's view; master is the environment (phy + kernel) side.
interface lii_stream_adapter_if #(
  parameter int unsigned PW = 64,
  parameter int unsigned IW = 48,
  parameter int unsigned OW = 8
);
  logic [PW-1:0] lii_in_p0_tdata;
  logic          lii_in_p0_tvalid;
  logic          lii_in_p0_tready;
  logic [7:0]    lii_in_p0_src;
  logic [7:0]    lii_in_p0_dst;

  logic [PW-1:0] lii_out_p0_tdata;
  logic          lii_out_p0_tvalid;
  logic          lii_out_p0_tready;
  logic [7:0]    lii_out_p0_src;
  logic [7:0]    lii_out_p0_dst;

  logic [IW-1:0] in_stream_tdata;
  logic          in_stream_tvalid;
  logic          in_stream_tready;

  logic [OW-1:0] out_stream_tdata;
  logic          out_stream_tvalid;
  logic          out_stream_tready;

  modport slave (
    input  lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst,
    output lii_in_p0_tready,
    output lii_out_p0_tdata, lii_out_p0_tvalid, lii_out_p0_src, lii_out_p0_dst,
    input  lii_out_p0_tready,
    output in_stream_tdata, in_stream_tvalid,
    input  in_stream_tready,
    input  out_stream_tdata, out_stream_tvalid,
    output out_stream_tready
  );

  modport master (
    output lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst,
    input  lii_in_p0_tready,
    input  lii_out_p0_tdata, lii_out_p0_tvalid, lii_out_p0_src, lii_out_p0_dst,
    output lii_out_p0_tready,
    input  in_stream_tdata, in_stream_tvalid,
    output in_stream_tready,
    output out_stream_tdata, out_stream_tvalid,
    input  out_stream_tready
  );
endinterface

// File: rtl/lii_stream_adapter.sv
// LII phy <-> HLS kernel stream adapter: inbound dst filter + deserialiser,
// outbound packer with src/dst stamping and idle-timeout flush of partial words.
module lii_stream_adapter #(
  parameter int unsigned PW           = 64,
  parameter int unsigned IW           = 48,
  parameter int unsigned OW           = 8,
  parameter logic [7:0]  NODE_ID      = 8'h00,
  parameter logic [7:0]  DEST_ID      = 8'h01,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic                  aclk,
  input  logic                  arst,
  lii_stream_adapter_if.slave   bus,
  output logic                  ce,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned IN_BEATS = (IW + PW - 1) / PW;
  localparam int unsigned PACK     = PW / OW;
  localparam int unsigned BcW      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int unsigned PkW      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned GW       = IN_BEATS * PW;

  // ---------------------------------------------------------------- input path
  logic [GW-1:0]  gather_q, gather_d;
  logic [BcW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]  hold_q, hold_d;
  logic           hold_valid_q, hold_valid_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           in_ready, in_accept, in_match;

  assign in_ready  = !hold_valid_q | bus.in_stream_tready;
  assign in_accept = bus.lii_in_p0_tvalid & in_ready;
  assign in_match  = (bus.lii_in_p0_dst == NODE_ID);

  always_comb begin
    gather_d     = gather_q;
    beat_cnt_d   = beat_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    drop_cnt_d   = drop_cnt_q;
    if (hold_valid_q && bus.in_stream_tready) begin
      hold_valid_d = 1'b0;
    end
    if (in_accept) begin
      if (!in_match) begin
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end else begin
        gather_d[int'(beat_cnt_q) * PW +: PW] = bus.lii_in_p0_tdata;
        if (beat_cnt_q == BcW'(IN_BEATS - 1)) begin
          // Bits of the last beat above IW are dropped by this truncation.
          hold_d       = gather_d[IW-1:0];
          hold_valid_d = 1'b1;
          beat_cnt_d   = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      gather_q     <= '0;
      beat_cnt_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      gather_q     <= gather_d;
      beat_cnt_q   <= beat_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.lii_in_p0_tready = in_ready;
  assign bus.in_stream_tdata  = hold_q;
  assign bus.in_stream_tvalid = hold_valid_q;
  assign drop_cnt             = drop_cnt_q;

  // --------------------------------------------------------------- output path
  typedef enum logic [0:0] {StPacking, StFull} pk_state_e;

  pk_state_e      state_q;
  logic [PkW-1:0] pk_cnt_q;
  logic [31:0]    idle_cnt_q;
  logic [PW-1:0]  pack_buf_q, out_data_q, pack_merge;
  logic           out_valid_q, out_ready, kernel_hs, flush_hit, idle_run;

  assign out_ready = !(out_valid_q & !bus.lii_out_p0_tready);
  assign kernel_hs = bus.out_stream_tvalid & out_ready;
  assign idle_run  = (FLUSH_CYCLES != 0) && (state_q == StPacking) && (pk_cnt_q != '0);
  assign flush_hit = idle_run && (idle_cnt_q == FLUSH_CYCLES - 1);

  always_comb begin
    pack_merge = pack_buf_q;
    pack_merge[int'(pk_cnt_q) * OW +: OW] = bus.out_stream_tdata;
  end

  // pack_buf_q is cleared on every emission so unfilled slots of a flushed word read as zero.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q     <= StPacking;
      pk_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      pack_buf_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state_q == StFull && bus.lii_out_p0_tready) begin
        out_valid_q <= 1'b0;
        state_q     <= StPacking;
      end
      // A handshake in the send cycle lands in slot 0 and overrides the FULL->PACKING move
      // only when it completes a word (PACK == 1).
      if (kernel_hs) begin
        idle_cnt_q <= '0;
        if (pk_cnt_q == PkW'(PACK - 1)) begin
          out_data_q  <= pack_merge;
          out_valid_q <= 1'b1;
          state_q     <= StFull;
          pack_buf_q  <= '0;
          pk_cnt_q    <= '0;
        end else begin
          pack_buf_q <= pack_merge;
          pk_cnt_q   <= pk_cnt_q + 1'b1;
        end
      end else if (flush_hit) begin
        out_data_q  <= pack_buf_q;
        out_valid_q <= 1'b1;
        state_q     <= StFull;
        pack_buf_q  <= '0;
        pk_cnt_q    <= '0;
        idle_cnt_q  <= '0;
      end else if (idle_run) begin
        idle_cnt_q <= idle_cnt_q + 32'd1;
      end
    end
  end

  assign bus.lii_out_p0_tdata  = out_data_q;
  assign bus.lii_out_p0_tvalid = out_valid_q;
  assign bus.lii_out_p0_src    = NODE_ID;
  assign bus.lii_out_p0_dst    = DEST_ID;
  assign bus.out_stream_tready = out_ready;
  assign ce                    = out_ready;

endmodule
